aes_key_expander: RTL and testbench

Iterative AES-128 key-schedule unit for the std_aes datapath. Loads a 128-bit cipher key and emits round keys 0..10 one at a time, in order, over a valid/ready handshake. The consumer is the round datapath: the AddRoundKey XOR network and the round-state register. Exactly one round key is computed per accepted beat, so the datapath can stall the schedule freely.

---
 rtl/aes_key_expander.sv | 136 +++++++++++++
 tb/tb_aes_key_expander.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: loads a cipher key and hands out round keys 0..10,
// one per accepted valid/ready beat.
module aes_key_expander #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  generate
    if (NR != 10) begin : g_nr_check
      $error("aes_key_expander: only NR=10 (AES-128) is supported");
    end
  endgenerate

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [7:0]   rcon;
  logic         accept;
  logic         load_go;
  logic         last_accept;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] rk_nxt;
  logic [7:0]   rcon_nxt;

  // RotWord folded into the S-box byte order, then the four-word XOR chain
  always_comb begin
    {w0, w1, w2, w3} = rk_out;
    t_word = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]}
             ^ {rcon, 24'h0};
    n0 = w0 ^ t_word;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    rk_nxt = {n0, n1, n2, n3};
    rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_load) state_nxt = RUN;
      RUN:     if (rk_ready && rk_round == LAST_ROUND) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rk_valid    = (state == RUN);
    busy        = (state == RUN);
    load_go     = (state == IDLE) && key_load;
    accept      = (state == RUN) && rk_ready;
    last_accept = accept && (rk_round == LAST_ROUND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_out   <= '0;
      rk_round <= '0;
      rcon     <= 8'h01;
      done     <= 1'b0;
    end else begin
      done <= last_accept;
      if (load_go) begin
        rk_out   <= key_in;
        rk_round <= '0;
        rcon     <= 8'h01;
      end else if (accept && !last_accept) begin
        rk_out   <= rk_nxt;
        rk_round <= rk_round + 4'd1;
        rcon     <= rcon_nxt;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander against FIPS-197 key-schedule vectors.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp_rk [0:10];
  bit           exp_known [0:10];

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  aes_key_expander #(.NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_load (key_load),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a1();
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i <= 10; i++) exp_known[i] = 1'b1;
  endtask

  task automatic set_zero();
    for (int i = 0; i <= 10; i++) begin
      exp_known[i] = 1'b0;
      exp_rk[i]    = '0;
    end
    exp_rk[1]  = 128'h62636363626363636263636362636363;
    exp_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    exp_known[0]  = 1'b1;
    exp_known[1]  = 1'b1;
    exp_known[10] = 1'b1;
  endtask

  task automatic do_load(input logic [127:0] key);
    key_in   = key;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Consumes one schedule; returns in the done cycle so a caller can reload there.
  task automatic run_sched(input string name, input int stall_pct, input int busy_round,
                           input int done_at);
    int           cyc = 1;
    int           exp_round = 0;
    int           accepts = 0;
    bit           stalled = 1'b0;
    bit           seen_done = 1'b0;
    bit           busy_ld_done = 1'b0;
    logic [127:0] prev_rk = '0;
    logic [3:0]   prev_rd = '0;
    while (cyc < 200) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (key_load) key_load = 1'b0;
      if (rk_valid) begin
        if (stalled) begin
          chk({name, " stall rk_out"}, rk_out, prev_rk);
          chk({name, " stall rk_round"}, 128'(rk_round), 128'(prev_rd));
        end
        if (busy_round >= 0 && int'(rk_round) == busy_round && !busy_ld_done) begin
          key_in       = '1;
          key_load     = 1'b1;
          busy_ld_done = 1'b1;
        end
        rk_ready = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
        if (rk_ready) begin
          chk({name, " round index"}, 128'(rk_round), 128'(exp_round));
          if (exp_round <= 10 && exp_known[exp_round])
            chk({name, $sformatf(" rk%0d", exp_round)}, rk_out, exp_rk[exp_round]);
          accepts++;
          exp_round++;
        end
        stalled = !rk_ready;
        prev_rk = rk_out;
        prev_rd = rk_round;
      end
      tick();
      cyc++;
    end
    rk_ready = 1'b1;
    chk({name, " done seen"}, 128'(seen_done), 128'(1));
    chk({name, " accepts"}, 128'(accepts), 128'(11));
    if (done_at > 0) chk({name, " done cycle"}, 128'(cyc), 128'(done_at));
    chk({name, " valid low in done"}, 128'(rk_valid), 128'(0));
    chk({name, " busy low in done"}, 128'(busy), 128'(0));
  endtask

  initial begin
    #3;
    chk("reset rk_out", rk_out, '0);
    chk("reset rk_round", 128'(rk_round), 128'(0));
    chk("reset rk_valid", 128'(rk_valid), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("idle valid", 128'(rk_valid), 128'(0));

    set_a1();
    rk_ready = 1'b1;
    do_load(KEY_A1);
    run_sched("a1", 0, -1, 12);
    chk("a1 final round held", 128'(rk_round), 128'(10));
    chk("a1 final key held", rk_out, exp_rk[10]);
    tick();
    chk("a1 done width", 128'(done), 128'(0));

    do_load(KEY_A1);
    run_sched("bp", 30, -1, 0);
    tick();
    chk("bp done width", 128'(done), 128'(0));

    do_load(KEY_A1);
    run_sched("busyld", 0, 4, 12);
    tick();

    rk_ready = 1'b1;
    do_load(KEY_A1);
    for (int i = 0; i < 40 && !(rk_valid && rk_round == 4'd6); i++) tick();
    chk("rst reached r6", 128'(rk_round), 128'(6));
    #2 rst = 1'b1;
    #1;
    chk("async rst rk_out", rk_out, '0);
    chk("async rst rk_round", 128'(rk_round), 128'(0));
    chk("async rst rk_valid", 128'(rk_valid), 128'(0));
    chk("async rst busy", 128'(busy), 128'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no done in reset", 128'(done), 128'(0));
    end
    rst = 1'b0;
    tick();
    chk("no done after reset", 128'(done), 128'(0));
    chk("idle after reset", 128'(rk_valid), 128'(0));

    do_load(KEY_A1);
    run_sched("postrst", 0, -1, 12);

    set_zero();
    do_load(KEY_ZERO);
    chk("b2b r0 valid", 128'(rk_valid), 128'(1));
    chk("b2b r0 round", 128'(rk_round), 128'(0));
    chk("b2b r0 key", rk_out, KEY_ZERO);
    run_sched("zero", 0, -1, 12);
    tick();
    chk("zero done width", 128'(done), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
